// File: rtl/spy_fifo_pkg.sv
// +----------------------------------------------------------------------------+
// | spy_fifo_pkg : shared constants and defaults for the spy FIFO array        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package spy_fifo_pkg;

  localparam int              OVF_W   = 16;
  localparam logic [OVF_W-1:0] OVF_SAT = 16'hFFFF;

  localparam int DEF_N_CHANNELS = 4;
  localparam int DEF_DATA_WIDTH = 65;
  localparam int DEF_FIFO_DEPTH = 6;
  localparam int DEF_AF_MARGIN  = 8;
  localparam int DEF_SPY_DEPTH  = 5;

  // Width of a channel selector; never zero so a single-channel build still has a port.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spy_fifo_channel.sv
// +----------------------------------------------------------------------------+
// | spy_fifo_channel : one FWFT flow-control FIFO plus its write-history spy   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module spy_fifo_channel
  import spy_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int AF_MARGIN  = DEF_AF_MARGIN,
  parameter int SPY_DEPTH  = DEF_SPY_DEPTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic                  freeze_i,
  input  logic [SPY_DEPTH-1:0]  spy_addr_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  afull_o,
  output logic [OVF_W-1:0]      ovf_cnt_o,
  output logic [DATA_WIDTH-1:0] spy_rdata_o,
  output logic [SPY_DEPTH-1:0]  spy_wptr_o,
  output logic                  spy_wrapped_o
);

  localparam int ENTRIES     = 1 << FIFO_DEPTH;
  localparam int SPY_ENTRIES = 1 << SPY_DEPTH;
  localparam logic [FIFO_DEPTH:0] ENTRIES_C = (FIFO_DEPTH+1)'(ENTRIES);
  localparam logic [FIFO_DEPTH:0] AF_C      = (FIFO_DEPTH+1)'(AF_MARGIN);

  logic [DATA_WIDTH-1:0] fifo_mem [ENTRIES];
  logic [DATA_WIDTH-1:0] spy_mem  [SPY_ENTRIES];

  logic [FIFO_DEPTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_DEPTH:0]   count_q, count_d, free_d;
  logic                  empty_q, full_q, afull_q;
  logic [OVF_W-1:0]      ovf_q;
  logic [SPY_DEPTH-1:0]  spy_ptr_q;
  logic                  spy_wrapped_q;
  logic                  push, pop, spy_cap;

  // Accept/pop decisions use the registered flags, i.e. the pre-edge occupancy.
  always_comb begin
    push    = we_i & ~full_q;
    pop     = re_i & ~empty_q;
    spy_cap = we_i & ~freeze_i;
    count_d = count_q + {{FIFO_DEPTH{1'b0}}, push} - {{FIFO_DEPTH{1'b0}}, pop};
    free_d  = ENTRIES_C - count_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      empty_q       <= 1'b1;
      full_q        <= 1'b0;
      afull_q       <= 1'b0;
      ovf_q         <= '0;
      spy_ptr_q     <= '0;
      spy_wrapped_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + (FIFO_DEPTH)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (FIFO_DEPTH)'(1);
      count_q <= count_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == ENTRIES_C);
      afull_q <= (free_d <= AF_C);
      if (we_i && full_q && (ovf_q != OVF_SAT)) ovf_q <= ovf_q + OVF_W'(1);
      if (spy_cap) begin
        spy_ptr_q <= spy_ptr_q + (SPY_DEPTH)'(1);
        if (&spy_ptr_q) spy_wrapped_q <= 1'b1;
      end
    end
  end

  // Storage is left unreset so it maps onto RAM; writes are suppressed during reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i && push) fifo_mem[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && spy_cap) spy_mem[spy_ptr_q] <= wdata_i;
  end

  assign rdata_o       = fifo_mem[rd_ptr_q];
  assign spy_rdata_o   = spy_mem[spy_addr_i];
  assign empty_o       = empty_q;
  assign full_o        = full_q;
  assign afull_o       = afull_q;
  assign ovf_cnt_o     = ovf_q;
  assign spy_wptr_o    = spy_ptr_q;
  assign spy_wrapped_o = spy_wrapped_q;

endmodule

`default_nettype wire

// File: rtl/spy_fifo_array.sv
// +----------------------------------------------------------------------------+
// | spy_fifo_array : N independent spy FIFO channels with shared spy readback  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module spy_fifo_array
  import spy_fifo_pkg::*;
#(
  parameter int N_CHANNELS = DEF_N_CHANNELS,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int AF_MARGIN  = DEF_AF_MARGIN,
  parameter int SPY_DEPTH  = DEF_SPY_DEPTH
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic [DATA_WIDTH-1:0]             write_data     [N_CHANNELS],
  input  logic                              write_enable   [N_CHANNELS],
  output logic [DATA_WIDTH-1:0]             read_data      [N_CHANNELS],
  input  logic                              read_enable    [N_CHANNELS],
  output logic                              empty          [N_CHANNELS],
  output logic                              full           [N_CHANNELS],
  output logic                              almost_full    [N_CHANNELS],
  output logic [OVF_W-1:0]                  overflow_count [N_CHANNELS],
  input  logic                              freeze,
  input  logic [sel_width(N_CHANNELS)-1:0]  spy_channel,
  input  logic [SPY_DEPTH-1:0]              spy_addr,
  output logic [DATA_WIDTH-1:0]             spy_data,
  output logic [SPY_DEPTH-1:0]              spy_write_ptr  [N_CHANNELS],
  output logic                              spy_wrapped    [N_CHANNELS]
);

  localparam int SPY_SEL_W = sel_width(N_CHANNELS);

  logic [DATA_WIDTH-1:0] chan_spy_rdata [N_CHANNELS];
  logic [DATA_WIDTH-1:0] spy_data_d, spy_data_q;

  for (genvar c = 0; c < N_CHANNELS; c++) begin : g_chan
    spy_fifo_channel #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH),
      .AF_MARGIN  (AF_MARGIN),
      .SPY_DEPTH  (SPY_DEPTH)
    ) u_chan (
      .clk_i         (clock),
      .rst_i         (reset_n),
      .wdata_i       (write_data[c]),
      .we_i          (write_enable[c]),
      .re_i          (read_enable[c]),
      .freeze_i      (freeze),
      .spy_addr_i    (spy_addr),
      .rdata_o       (read_data[c]),
      .empty_o       (empty[c]),
      .full_o        (full[c]),
      .afull_o       (almost_full[c]),
      .ovf_cnt_o     (overflow_count[c]),
      .spy_rdata_o   (chan_spy_rdata[c]),
      .spy_wptr_o    (spy_write_ptr[c]),
      .spy_wrapped_o (spy_wrapped[c])
    );
  end

  // Selector codes with no matching channel fall through to zero.
  always_comb begin
    spy_data_d = '0;
    for (int c = 0; c < N_CHANNELS; c++) begin
      if (spy_channel == SPY_SEL_W'(c)) spy_data_d = chan_spy_rdata[c];
    end
  end

  always_ff @(posedge clock) begin
    if (reset_n) spy_data_q <= '0;
    else         spy_data_q <= spy_data_d;
  end

  assign spy_data = spy_data_q;

endmodule

`default_nettype wire
